dotprod_vec_loader: RTL and testbench

- Upstream feeder for the bfloat16 dot-product pipeline.
- Accepts one (horz, vert) bfloat16 element pair per beat over a valid/ready stream.
- Packs the pairs into full-width horz/vert vectors and presents each completed vector to the dot-product stage with a valid/ready handshake.
- Short vectors, terminated by in_last, are zero-padded so the padding contributes +0 to the sum.

---
 rtl/dotprod_vec_loader.sv | 84 ++++++++
 tb/tb_dotprod_vec_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dotprod_vec_loader.sv
// dotprod_vec_loader: packs streamed bfloat16 (horz, vert) pairs into zero-padded vectors for the dot-product stage.
module dotprod_vec_loader #(
    parameter int vec_length = 10,
    localparam int bit_length = vec_length * 16,
    localparam int cnt_w = $clog2(vec_length + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_horz,
    input  logic [15:0]           in_vert,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:bit_length-1] horz,
    output logic [0:bit_length-1] vert,
    output logic [cnt_w-1:0]      out_count
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t                state_q, state_d;
    logic [cnt_w-1:0]      count_q, count_d;
    logic [cnt_w-1:0]      out_count_q, out_count_d;
    logic                  out_valid_q, out_valid_d;
    logic [0:bit_length-1] horz_q, horz_d;
    logic [0:bit_length-1] vert_q, vert_d;

    assign in_ready  = (state_q == FILL);
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign horz      = horz_q;
    assign vert      = vert_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_count_d = out_count_q;
        out_valid_d = out_valid_q;
        horz_d      = horz_q;
        vert_d      = vert_q;
        if (state_q == FILL && in_valid) begin
            for (int i = 0; i < vec_length; i++) begin
                if (count_q == cnt_w'(i)) begin
                    horz_d[i*16 +: 16] = in_horz;
                    vert_d[i*16 +: 16] = in_vert;
                end
            end
            if (in_last || count_q == cnt_w'(vec_length - 1)) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_count_d = count_q + 1'b1;
                count_d     = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (state_q == HOLD && out_ready) begin
            // clearing here is what makes the unwritten tail of the next vector read as +0
            state_d     = FILL;
            out_valid_d = 1'b0;
            out_count_d = '0;
            horz_d      = '0;
            vert_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            count_q     <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            horz_q      <= '0;
            vert_q      <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            horz_q      <= horz_d;
            vert_q      <= vert_d;
        end
    end
endmodule

// File: tb/tb_dotprod_vec_loader.sv
// tb_dotprod_vec_loader: directed table vectors, multi-cycle corner sequences and a scoreboarded random-gap run.
module tb_dotprod_vec_loader;
    localparam int VL = 10;
    localparam int BL = VL * 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic [15:0]   in_horz = '0;
    logic [15:0]   in_vert = '0;
    logic          in_ready;
    logic          out_valid;
    logic [0:BL-1] horz;
    logic [0:BL-1] vert;
    logic [CW-1:0] out_count;

    dotprod_vec_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_horz(in_horz), .in_vert(in_vert), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .horz(horz), .vert(vert), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        bit          lst;
        logic [15:0] hb;
        logic [15:0] hs;
        logic [15:0] vb;
        logic [15:0] vs;
        int          ecnt;
    } vec_t;

    typedef struct {
        logic [0:BL-1] h;
        logic [0:BL-1] v;
        int            cnt;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;
    bit   rnd_on = 0;
    exp_t sb[$];

    task automatic chk(input string name, input logic [BL-1:0] got, input logic [BL-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic beat(input logic [15:0] h, input logic [15:0] v, input logic l);
        bit ok;
        int g;
        g = 0;
        in_valid = 1'b1;
        in_horz = h;
        in_vert = v;
        in_last = l;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            g++;
        end while (!ok && g < 200);
        if (!ok) chk("beat_timeout", 0, 1);
        // junk on idle lanes, including in_last, must be ignored
        in_valid = 1'b0;
        in_horz = 16'hDEAD;
        in_vert = 16'hBEEF;
        in_last = 1'b1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_count"}, out_count, 0);
        chk({tag, "_horz"}, horz, 0);
        chk({tag, "_vert"}, vert, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    always @(negedge clk) begin
        if (rnd_on && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_vector", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_pop++;
                chk("sb_horz", horz, e.h);
                chk("sb_vert", vert, e.v);
                chk("sb_out_count", out_count, e.cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[5];
        logic [0:BL-1] eh;
        logic [0:BL-1] ev;
        tbl[0] = '{10, 1'b1, 16'h3F80, 16'h0000, 16'h4000, 16'h0000, 10};
        tbl[1] = '{10, 1'b0, 16'h0001, 16'h0001, 16'h8000, 16'h0001, 10};
        tbl[2] = '{1,  1'b1, 16'h7FC1, 16'h0000, 16'h0001, 16'h0000, 1};
        tbl[3] = '{5,  1'b1, 16'hFF80, 16'h0001, 16'h0080, 16'h0002, 5};
        tbl[4] = '{9,  1'b1, 16'h1234, 16'h1111, 16'hABCD, 16'h0000, 9};

        tick();
        tick();
        chk_reset_state("reset");
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk_reset_state("post_reset");

        foreach (tbl[r]) begin
            eh = '0;
            ev = '0;
            for (int i = 0; i < tbl[r].len; i++) begin
                eh[i*16 +: 16] = 16'(tbl[r].hb + i * tbl[r].hs);
                ev[i*16 +: 16] = 16'(tbl[r].vb + i * tbl[r].vs);
                beat(eh[i*16 +: 16], ev[i*16 +: 16], (i == tbl[r].len - 1) && tbl[r].lst);
            end
            chk($sformatf("row%0d_out_valid", r), out_valid, 1);
            chk($sformatf("row%0d_out_count", r), out_count, tbl[r].ecnt);
            chk($sformatf("row%0d_horz", r), horz, eh);
            chk($sformatf("row%0d_vert", r), vert, ev);
            tick();
            chk($sformatf("row%0d_drop_valid", r), out_valid, 0);
            chk($sformatf("row%0d_in_ready", r), in_ready, 1);
            chk($sformatf("row%0d_cleared", r), horz, 0);
        end

        // short vector held while upstream keeps offering a new beat
        out_ready = 1'b0;
        beat(16'h3F80, 16'h4000, 1'b0);
        beat(16'h4040, 16'h4000, 1'b0);
        beat(16'h4080, 16'h4000, 1'b1);
        eh = '0;
        ev = '0;
        eh[0:47] = {16'h3F80, 16'h4040, 16'h4080};
        ev[0:47] = {16'h4000, 16'h4000, 16'h4000};
        in_valid = 1'b1;
        in_horz = 16'hAAAA;
        in_vert = 16'h5555;
        in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_count", out_count, 3);
            chk("stall_horz", horz, eh);
            chk("stall_vert", vert, ev);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("unstall_in_ready", in_ready, 1);
        chk("unstall_out_valid", out_valid, 0);
        chk("unstall_cleared", horz, 0);
        tick();
        in_valid = 1'b0;
        eh = '0;
        ev = '0;
        eh[0:15] = 16'hAAAA;
        ev[0:15] = 16'h5555;
        chk("pending_horz", horz, eh);
        chk("pending_vert", vert, ev);
        beat(16'hBBBB, 16'h6666, 1'b1);
        eh[16:31] = 16'hBBBB;
        chk("pending_done_horz", horz, eh);
        chk("pending_done_count", out_count, 2);
        tick();

        // reset mid-fill discards the partial vector
        for (int i = 0; i < 4; i++) beat(16'h1111, 16'h2222, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_state("midfill_reset");
        eh = '0;
        ev = '0;
        for (int i = 0; i < VL; i++) begin
            eh[i*16 +: 16] = 16'(16'h0100 + i);
            ev[i*16 +: 16] = 16'(16'h0200 + i);
            beat(eh[i*16 +: 16], ev[i*16 +: 16], i == VL - 1);
        end
        chk("after_reset_horz", horz, eh);
        chk("after_reset_vert", vert, ev);
        chk("after_reset_count", out_count, 10);
        tick();

        // reset while holding, with out_ready asserted on the same edge
        out_ready = 1'b0;
        beat(16'h7777, 16'h8888, 1'b0);
        beat(16'h9999, 16'hAAAA, 1'b1);
        chk("hold_before_reset", out_valid, 1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        chk_reset_state("hold_reset");
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("hold_reset_no_ghost", out_valid, 0);
        end

        rnd_on = 1;
        for (int n = 0; n < 60; n++) begin
            exp_t e;
            int   len;
            len = $urandom_range(1, VL);
            e.h = '0;
            e.v = '0;
            e.cnt = len;
            for (int i = 0; i < len; i++) begin
                e.h[i*16 +: 16] = 16'($urandom);
                e.v[i*16 +: 16] = 16'($urandom);
            end
            sb.push_back(e);
            for (int i = 0; i < len; i++) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) tick();
                beat(e.h[i*16 +: 16], e.v[i*16 +: 16],
                     (i == len - 1) && (len < VL || $urandom_range(0, 1) == 1));
            end
        end
        for (int g = 0; g < 200 && sb.size() > 0; g++) tick();
        chk("sb_drained", sb.size(), 0);
        chk("sb_vector_total", n_pop, 60);
        rnd_on = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
